// File: rtl/fifo_in_pkg.sv
// ============================================================================
// Module      : fifo_in_pkg
// Description : Shared constants and helpers for the multi-channel FIFO writer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_in_pkg;

    localparam logic [15:0] DROP_SAT     = 16'hFFFF;
    localparam int          c_SAMPLE_LSB = 0;

    // Channel tag needs at least one bit even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The channel tag sits directly above the sample.
    function automatic int ch_lsb(input int sample_w);
        return c_SAMPLE_LSB + sample_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_in_sfifo.sv
// ============================================================================
// Module      : fifo_in_sfifo
// Description : Synchronous register FIFO with push, pop, flush and level
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_in_sfifo
    import fifo_in_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wp;
    logic [c_AW-1:0]  r_rp;
    logic [c_AW:0]    r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rp];
    assign o_level   = r_cnt;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_in_mc_writer.sv
// ============================================================================
// Module      : fifo_in_mc_writer
// Description : Round-robin multi-channel sample collector feeding an
//               Avalon-MM write port through a local FIFO
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_in_mc_writer
    import fifo_in_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int SAMPLE_W     = 16,
    parameter int BUS_W        = 32,
    parameter int DEPTH        = 16,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic                         fifo_in_write,
    output logic [BUS_W-1:0]             fifo_in_writedata,
    input  logic                         fifo_in_waitrequest,
    output logic [$clog2(DEPTH):0]       level,
    output logic [15:0]                  drop_count
);

    localparam int c_CH_W   = clog2_min1(NUM_CH);
    localparam int c_WORD_W = ch_lsb(SAMPLE_W) + c_CH_W;

    if (c_WORD_W > BUS_W) begin : g_bus_too_narrow
        $error("fifo_in_mc_writer: SAMPLE_W + CH_W exceeds BUS_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_in_mc_writer: DEPTH must be a power of 2 and >= 2");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
        $error("fifo_in_mc_writer: NUM_CH must be within 1..16");
    end

    logic [c_CH_W-1:0]       r_rr;
    logic                    r_wr;
    logic [BUS_W-1:0]        r_wd;
    logic [15:0]             r_drop;

    logic [2*NUM_CH-1:0]     w_rot;
    logic                    w_any;
    logic [c_CH_W-1:0]       w_gidx;
    logic                    w_accept_ok;
    logic                    w_xfer;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_pop;
    logic [SAMPLE_W-1:0]     w_sample;
    logic [c_WORD_W-1:0]     w_word;
    logic [c_WORD_W-1:0]     w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_level;

    // Rotate the valid vector so bit 0 is the channel at the rr pointer.
    assign w_rot = {ch_valid, ch_valid} >> r_rr;

    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any  = 1'b1;
                w_gidx = c_CH_W'((int'(r_rr) + i) % NUM_CH);
            end
        end
    end

    assign w_accept_ok = DROP_ON_FULL ? 1'b1 : ~w_full;
    assign w_xfer      = w_any & enable & w_accept_ok & ~reset_reset;
    assign ch_ready    = w_xfer ? (NUM_CH'(1) << w_gidx) : '0;

    // A sample lost to a flush is not a drop; only a genuinely full FIFO is.
    assign w_push   = w_xfer & ~w_full & ~flush;
    assign w_drop   = w_xfer & w_full & ~flush;
    assign w_sample = ch_data[int'(w_gidx)*SAMPLE_W +: SAMPLE_W];
    assign w_word   = {w_gidx, w_sample};
    assign w_pop    = ~w_empty & (~r_wr | ~fifo_in_waitrequest);

    fifo_in_sfifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (DEPTH)
    ) u_sfifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_data  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rr   <= '0;
            r_wr   <= 1'b0;
            r_wd   <= '0;
            r_drop <= '0;
        end else begin
            if (w_xfer) begin
                r_rr <= (w_gidx == c_CH_W'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
            end
            if (w_pop) begin
                r_wr <= 1'b1;
                r_wd <= BUS_W'(w_head);
            end else if (r_wr && !fifo_in_waitrequest) begin
                r_wr <= 1'b0;
            end
            if (w_drop && (r_drop != DROP_SAT)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign fifo_in_write     = r_wr;
    assign fifo_in_writedata = r_wd;
    assign level             = w_level;
    assign drop_count        = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_fifo_in_mc_writer.sv
// ============================================================================
// Module      : tb_fifo_in_mc_writer
// Description : Directed self-checking bench, backpressure and drop variants
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_in_mc_writer;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 16;
    localparam int BUS_W    = 32;
    localparam int DEPTH    = 16;

    logic                        clk_clk     = 1'b0;
    logic                        reset_reset = 1'b0;
    logic                        enable      = 1'b0;
    logic                        flush       = 1'b0;
    logic [NUM_CH-1:0]           ch_valid    = '0;
    logic [NUM_CH*SAMPLE_W-1:0]  ch_data     = '0;
    logic                        waitreq     = 1'b0;

    logic [NUM_CH-1:0]           bp_ready, dr_ready;
    logic                        bp_write, dr_write;
    logic [BUS_W-1:0]            bp_wd, dr_wd;
    logic [4:0]                  bp_level, dr_level;
    logic [15:0]                 bp_drop, dr_drop;

    int n_chk = 0;
    int n_err = 0;

    fifo_in_mc_writer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .DROP_ON_FULL(1'b0)
    ) u_bp (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable), .flush(flush),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(bp_ready),
        .fifo_in_write(bp_write), .fifo_in_writedata(bp_wd),
        .fifo_in_waitrequest(waitreq), .level(bp_level), .drop_count(bp_drop)
    );

    fifo_in_mc_writer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .DROP_ON_FULL(1'b1)
    ) u_dr (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable), .flush(flush),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(dr_ready),
        .fifo_in_write(dr_write), .fifo_in_writedata(dr_wd),
        .fifo_in_waitrequest(waitreq), .level(dr_level), .drop_count(dr_drop)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] v);
        ch_data[ch*SAMPLE_W +: SAMPLE_W] = v;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        reset_reset = 1'b1;
        ch_valid    = '0;
        flush       = 1'b0;
        waitreq     = 1'b0;
        tick();
        tick();
        reset_reset = 1'b0;
    endtask

    initial begin
        int          n_wr;
        int          n_sent;
        logic        acc;
        logic [31:0] exp;

        // Reset state, with valid channels present to prove ready is gated
        #1;
        reset_reset = 1'b1;
        enable      = 1'b1;
        ch_valid    = 4'hF;
        #2;
        check("rst_ready", 32'(bp_ready), 32'h0);
        check("rst_write", 32'(bp_write), 32'h0);
        check("rst_wdata", bp_wd, 32'h0);
        check("rst_level", 32'(bp_level), 32'h0);
        check("rst_drop",  32'(dr_drop), 32'h0);
        do_reset();

        // Single sample on channel 2, written two cycles later
        set_ch(2, 16'hABCD);
        ch_valid = 4'b0100;
        #1;
        check("single_ready", 32'(bp_ready), 32'h4);
        tick();
        ch_valid = '0;
        check("single_t1_write", 32'(bp_write), 32'h0);
        check("single_t1_level", 32'(bp_level), 32'h1);
        tick();
        check("single_t2_write", 32'(bp_write), 32'h1);
        check("single_t2_wdata", bp_wd, 32'h0002_ABCD);
        check("single_t2_level", 32'(bp_level), 32'h0);
        tick();
        check("single_t3_write", 32'(bp_write), 32'h0);
        enable   = 1'b0;
        ch_valid = 4'b0001;
        #1;
        check("disabled_ready", 32'(bp_ready), 32'h0);
        enable   = 1'b1;
        ch_valid = '0;

        // Round-robin with all channels valid
        do_reset();
        for (int ch = 0; ch < NUM_CH; ch++) set_ch(ch, 16'hC000 + 16'(ch));
        ch_valid = 4'hF;
        n_wr = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 12) ch_valid = '0;
            #1;
            if (c < 12) check("rr_ready", 32'(bp_ready), 32'(1) << (c % 4));
            if (bp_write) begin
                exp = (32'(n_wr % 4) << 16) | (32'hC000 + 32'(n_wr % 4));
                check("rr_word", bp_wd, exp);
                n_wr++;
            end
            tick();
        end
        check("rr_count", 32'(n_wr), 32'd12);

        // Backpressure: stall downstream while channel 0 streams
        do_reset();
        waitreq  = 1'b1;
        ch_valid = 4'b0001;
        n_sent   = 0;
        for (int c = 0; c < 25; c++) begin
            set_ch(0, 16'h5000 + 16'(n_sent));
            #1;
            acc = bp_ready[0];
            if (bp_write) check("bp_wd_stable", bp_wd, 32'h0000_5000);
            tick();
            if (acc) n_sent++;
        end
        check("bp_accepted", 32'(n_sent), 32'd17);
        check("bp_level_full", 32'(bp_level), 32'd16);
        check("bp_ready_low", 32'(bp_ready), 32'h0);
        check("bp_write_held", 32'(bp_write), 32'h1);
        ch_valid = '0;
        waitreq  = 1'b0;
        n_wr     = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (bp_write) begin
                check("bp_drain_word", bp_wd, 32'h0000_5000 + 32'(n_wr));
                n_wr++;
            end
            tick();
        end
        check("bp_drain_count", 32'(n_wr), 32'd17);
        check("bp_drain_level", 32'(bp_level), 32'h0);

        // Drop mode: 20 samples into a stalled path on channel 1
        do_reset();
        waitreq = 1'b1;
        set_ch(1, 16'h7777);
        ch_valid = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("drop_ready", 32'(dr_ready), 32'h2);
            tick();
        end
        check("drop_count3", 32'(dr_drop), 32'd3);
        check("drop_level", 32'(dr_level), 32'd16);
        check("drop_write", 32'(dr_write), 32'h1);
        check("drop_wdata", dr_wd, 32'h0001_7777);
        for (int c = 0; c < 65531; c++) tick();
        check("drop_pre_sat", 32'(dr_drop), 32'h0000_FFFE);
        tick();
        check("drop_sat", 32'(dr_drop), 32'h0000_FFFF);
        repeat (5) tick();
        check("drop_sat_hold", 32'(dr_drop), 32'h0000_FFFF);
        check("drop_ready_sat", 32'(dr_ready), 32'h2);

        // Flush while a write is stalled
        do_reset();
        waitreq = 1'b1;
        set_ch(3, 16'h3300);
        ch_valid = 4'b1000;
        repeat (9) tick();
        ch_valid = '0;
        check("flush_pre_level", 32'(bp_level), 32'd8);
        check("flush_pre_write", 32'(bp_write), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", 32'(bp_level), 32'h0);
        check("flush_write_kept", 32'(bp_write), 32'h1);
        check("flush_wdata_kept", bp_wd, 32'h0003_3300);
        waitreq = 1'b0;
        tick();
        check("flush_write_done", 32'(bp_write), 32'h0);
        n_wr = 0;
        for (int c = 0; c < 5; c++) begin
            if (bp_write) n_wr++;
            tick();
        end
        check("flush_no_more", 32'(n_wr), 32'h0);

        // Asynchronous reset mid-stream
        do_reset();
        waitreq  = 1'b1;
        ch_valid = 4'hF;
        repeat (5) tick();
        check("areset_pre_level", 32'(bp_level), 32'd4);
        #2;
        reset_reset = 1'b1;
        #1;
        check("areset_write", 32'(bp_write), 32'h0);
        check("areset_level", 32'(bp_level), 32'h0);
        check("areset_ready", 32'(bp_ready), 32'h0);
        tick();
        reset_reset = 1'b0;
        waitreq     = 1'b0;
        #1;
        check("areset_first_grant", 32'(bp_ready), 32'h1);
        tick();
        check("areset_second_grant", 32'(bp_ready), 32'h2);
        ch_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
